// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide sequencer for the P7 pipeline.
// Owns the HI/LO architectural registers, runs a fixed-latency busy
// countdown per mult/div operation, commits the result when it expires,
// and stalls ID for mult/div-class instructions while the unit is occupied.
// Optional build macro: MD_EARLY_DIV0_EN -- when defined, a divide by zero
// occupies the unit for a single cycle instead of the full divide latency.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        id_md,
  input  logic        req,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        start_acc;
  logic        commit;
  logic        div_zero;
  logic [3:0]  cnt_load;
  logic [63:0] md_res;

  // Full 64-bit product; op bit 0 clear selects signed operands.
  function automatic logic [63:0] mul_full(input logic sgn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; quotient truncates toward zero and the
  // signed remainder follows the dividend's sign. Caller keeps b non-zero.
  function automatic logic [63:0] div_full(input logic sgn,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic        [31:0] q, r;
    sa = a;
    sb = b;
    if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign start_acc = start && !op[2] && !req && (state_q == IDLE);
  assign commit    = (state_q == BUSY) && (cnt_q == 4'd1);
  assign div_zero  = op_q[1] && (b_q == 32'd0);

  // Result of the latched operation; divisor forced non-zero to keep the
  // divider defined, the write itself is suppressed on divide by zero.
  always_comb begin
    md_res = 64'd0;
    if (op_q[1])
      md_res = div_full(!op_q[0], a_q, (b_q == 32'd0) ? 32'd1 : b_q);
    else
      md_res = mul_full(!op_q[0], a_q, b_q);
  end

  // Countdown length selected by the incoming operation.
  always_comb begin
    cnt_load = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
`ifdef MD_EARLY_DIV0_EN
    if (op[1] && (src_b == 32'd0))
      cnt_load = 4'd1;
`endif
  end

  // Next HI/LO: completed operation, else an mthi/mtlo write that lost no race.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      if (!div_zero) begin
        hi_d = md_res[63:32];
        lo_d = md_res[31:0];
      end
    end else if ((state_q == IDLE) && !req && !start_acc) begin
      if (mthi) hi_d = wdata;
      if (mtlo) lo_d = wdata;
    end
  end

  // Control FSM plus architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      case (state_q)
        IDLE: begin
          if (start_acc) begin
            state_q <= BUSY;
            cnt_q   <= cnt_load;
          end
        end
        BUSY: begin
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Operand capture on an accepted start; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      a_q  <= src_a;
      b_q  <= src_b;
      op_q <= op[1:0];
    end
  end

  assign busy  = (state_q == BUSY);
  assign stall = id_md && (start_acc || busy);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, arithmetic, hazards, req/reset.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        id_md;
  logic        req;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp;
  int n_err;

`ifdef MD_EARLY_DIV0_EN
  localparam int DIV0_N = 1;
`else
  localparam int DIV0_N = 10;
`endif

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
    .wdata(wdata), .id_md(id_md), .req(req),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble operands afterwards, check n busy cycles.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input int n);
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    start = 1'b0; src_a = 32'h5A5A_1234; src_b = 32'h0;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s_busy_T%0d", tag, i), {31'b0, busy}, 32'd1);
      tick();
    end
    check($sformatf("%s_idle_after", tag), {31'b0, busy}, 32'd0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1; start = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0; id_md = 1'b0; req = 1'b0;
    tick(); tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    tick();
    check("rst_stall", {31'b0, stall}, 32'd0);

    // mult -1 * 2 with id_md held: stall T..T+5, busy T+1..T+5,
    // start and mtlo during BUSY must be ignored.
    id_md = 1'b1; start = 1'b1; op = 3'd0; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
    #1;
    check("haz_stall_T", {31'b0, stall}, 32'd1);
    check("haz_busy_T", {31'b0, busy}, 32'd0);
    tick();
    start = 1'b0; src_a = 32'd7; src_b = 32'd9;
    for (int i = 1; i <= 5; i++) begin
      if (i == 2) begin start = 1'b1; op = 3'd3; end
      if (i == 3) begin start = 1'b0; mtlo = 1'b1; wdata = 32'h1234; end
      if (i == 4) mtlo = 1'b0;
      #1;
      check($sformatf("haz_busy_T%0d", i), {31'b0, busy}, 32'd1);
      check($sformatf("haz_stall_T%0d", i), {31'b0, stall}, 32'd1);
      tick();
    end
    check("haz_busy_T6", {31'b0, busy}, 32'd0);
    check("haz_stall_T6", {31'b0, stall}, 32'd0);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    id_md = 1'b0;

    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    run_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    run_op("divu", 3'd3, 32'd7, 32'd2, 10);
    check("divu_hi", hi, 32'd1);
    check("divu_lo", lo, 32'd3);

    // mtlo in IDLE
    mtlo = 1'b1; wdata = 32'h1234;
    tick();
    mtlo = 1'b0;
    check("mtlo_idle_lo", lo, 32'h1234);
    check("mtlo_idle_hi", hi, 32'd1);

    // mthi + mtlo together
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("mthilo_hi", hi, 32'h55);
    check("mthilo_lo", lo, 32'h55);

    // start and mthi in the same cycle: start wins, write dropped
    mthi = 1'b1; wdata = 32'h99;
    start = 1'b1; op = 3'd1; src_a = 32'd3; src_b = 32'd4;
    tick();
    mthi = 1'b0; start = 1'b0;
    check("race_hi_dropped", hi, 32'h55);
    for (int i = 1; i <= 5; i++) tick();
    check("race_busy_done", {31'b0, busy}, 32'd0);
    check("race_hi", hi, 32'd0);
    check("race_lo", lo, 32'd12);

    // op 4 is not a start
    start = 1'b1; op = 3'd4;
    tick();
    start = 1'b0;
    check("op4_busy", {31'b0, busy}, 32'd0);

    // req=1 suppresses start and mthi
    req = 1'b1; start = 1'b1; op = 3'd0; src_a = 32'd6; src_b = 32'd6;
    tick();
    start = 1'b0; mthi = 1'b1; wdata = 32'hDEAD;
    check("req_start_busy", {31'b0, busy}, 32'd0);
    tick();
    mthi = 1'b0; req = 1'b0;
    check("req_hi", hi, 32'd0);
    check("req_lo", lo, 32'd12);

    // req during BUSY does not abort the running operation
    start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
    tick();
    start = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 2; i <= 5; i++) tick();
    check("reqbusy_busy", {31'b0, busy}, 32'd0);
    check("reqbusy_hi", hi, 32'd0);
    check("reqbusy_lo", lo, 32'd15);

    // divide by zero leaves preset HI/LO untouched
    mthi = 1'b1; wdata = 32'hAA;
    tick();
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'hBB;
    tick();
    mtlo = 1'b0;
    run_op("div0", 3'd2, 32'd5, 32'd0, DIV0_N);
    check("div0_hi", hi, 32'hAA);
    check("div0_lo", lo, 32'hBB);

    // asynchronous reset at T+3 of a divide
    start = 1'b1; op = 3'd3; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick();
    check("rstmid_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", {31'b0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("rstmid_late_busy", {31'b0, busy}, 32'd0);
    check("rstmid_late_hi", hi, 32'd0);
    check("rstmid_late_lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
